// File: rtl/led_fade_pwm_pkg.sv
// Shared constants for the LED output stage: channel count, PWM width, pin polarity.
package led_fade_pwm_pkg;

    localparam int unsigned LEDS_NR_DEF    = 3;
    localparam int unsigned PWM_BITS_DEF   = 8;
    localparam int unsigned STEP_DIV_DEF   = 27000;
    localparam bit          ACTIVE_LOW_DEF = 1'b1;

    function automatic int unsigned duty_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fade_pwm_channel.sv
// One LED channel: saturating duty ramp toward its target, PWM comparator, registered pin.
module led_pwm_channel
    import led_fade_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
    parameter bit          ACTIVE_LOW = ACTIVE_LOW_DEF
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                step_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                target,
    output logic                led_pwm,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_tgt;
    logic                lit;

    // Full duty is forced lit so the pwm_cnt==MAX cycle does not blink off.
    always_comb begin
        duty_tgt = target ? DUTY_MAX : '0;
        lit      = (duty == DUTY_MAX) || (pwm_cnt < duty);
    end

    assign busy = (duty != duty_tgt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty    <= '0;
            led_pwm <= ACTIVE_LOW;
        end else begin
            if (!en) begin
                duty <= duty_tgt;
            end else if (step_tick) begin
                if (target && duty != DUTY_MAX)
                    duty <= duty + 1'b1;
                else if (!target && duty != '0)
                    duty <= duty - 1'b1;
            end
            led_pwm <= (en ? lit : target) ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: registers the blink pattern and fades each pin via per-channel PWM.
module led_fade_pwm
    import led_fade_pwm_pkg::*;
#(
    parameter int unsigned LEDS_NR    = LEDS_NR_DEF,
    parameter int unsigned PWM_BITS   = PWM_BITS_DEF,
    parameter int unsigned STEP_DIV   = STEP_DIV_DEF,
    parameter bit          ACTIVE_LOW = ACTIVE_LOW_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEDS_NR-1:0] leds_in,
    output logic [LEDS_NR-1:0] led_pwm,
    output logic               busy
);

    localparam int unsigned     PS_W    = $clog2(STEP_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

    logic [LEDS_NR-1:0]  leds_q;
    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step_tick;
    logic [LEDS_NR-1:0]  ch_busy;

    assign step_tick = (prescaler == PS_LAST);

    // busy is masked in bypass so the one-cycle duty catch-up never shows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_q    <= '0;
            prescaler <= '0;
            pwm_cnt   <= '0;
            busy      <= 1'b0;
        end else begin
            leds_q    <= leds_in;
            prescaler <= step_tick ? '0 : prescaler + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            busy      <= en & (|ch_busy);
        end
    end

    for (genvar i = 0; i < LEDS_NR; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .step_tick (step_tick),
            .pwm_cnt   (pwm_cnt),
            .target    (leds_q[i]),
            .led_pwm   (led_pwm[i]),
            .busy      (ch_busy[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm against a cycle-level arithmetic reference model.
module tb_led_fade_pwm;

    localparam int MAXD = 15;
    localparam int SD   = 4;
    localparam bit AL   = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] leds_in = 3'b000;
    logic [2:0] led_pwm;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         m_duty [3];
    int         m_n;
    logic [2:0] m_leds_q;
    logic [2:0] m_led;
    logic       m_busy;

    always #5 clk = ~clk;

    led_fade_pwm #(
        .LEDS_NR    (3),
        .PWM_BITS   (4),
        .STEP_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .leds_in (leds_in),
        .led_pwm (led_pwm),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n      = 0;
        m_leds_q = 3'b000;
        m_led    = 3'b111;
        m_busy   = 1'b0;
        for (int i = 0; i < 3; i++) m_duty[i] = 0;
    endtask

    // One clock edge: advance the model from the pre-edge state, then compare.
    task automatic cycle();
        int         nd [3];
        logic [2:0] nl;
        logic       nb;
        bit         tick;
        int         pwm;
        int         tgt;
        @(posedge clk);
        tick = (m_n % SD) == (SD - 1);
        pwm  = m_n % (MAXD + 1);
        nb   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tgt = m_leds_q[i] ? MAXD : 0;
            if (en && m_duty[i] != tgt) nb = 1'b1;
            if (en) nl[i] = AL ^ ((m_duty[i] == MAXD) || (pwm < m_duty[i]));
            else    nl[i] = AL ^ m_leds_q[i];
            if (!en)                           nd[i] = tgt;
            else if (tick && m_duty[i] < tgt)  nd[i] = m_duty[i] + 1;
            else if (tick && m_duty[i] > tgt)  nd[i] = m_duty[i] - 1;
            else                               nd[i] = m_duty[i];
        end
        m_duty   = nd;
        m_led    = nl;
        m_busy   = nb;
        m_leds_q = leds_in;
        m_n++;
        #1;
        chk("led_pwm", 32'(led_pwm), 32'(m_led));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    // Called 1 time unit after a rising edge; asserts reset mid-cycle.
    task automatic async_reset(input int hold);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_pins_now", 32'(led_pwm), 32'h7);
        chk("reset_busy_now", 32'(busy), 32'h0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("reset_pins_hold", 32'(led_pwm), 32'h7);
            chk("reset_busy_hold", 32'(busy), 32'h0);
        end
        #3;
        rst = 1'b1;
    endtask

    task automatic run_until_duty0(input int d, input int bound);
        int k = 0;
        while (m_duty[0] != d && k < bound) begin
            cycle();
            k++;
        end
        if (m_duty[0] != d) begin
            checks++;
            errors++;
            $error("FAIL timeout_duty0 observed=%0d expected=%0d", m_duty[0], d);
        end
    endtask

    initial begin
        #6;
        async_reset(3);

        // Fade up channel 0
        en = 1'b1;
        leds_in = 3'b001;
        repeat (70) cycle();
        chk("fade_full_pin0", 32'(led_pwm[0]), 32'h0);
        chk("fade_other_pins", 32'(led_pwm[2:1]), 32'h3);
        chk("fade_done_busy", 32'(busy), 32'h0);

        // Fade down, then reverse mid-ramp at duty 8
        leds_in = 3'b000;
        repeat (70) cycle();
        leds_in = 3'b001;
        run_until_duty0(8, 80);
        leds_in = 3'b000;
        repeat (45) cycle();
        chk("reversal_off_pin0", 32'(led_pwm[0]), 32'h1);

        // Bypass: pins follow the pattern with 2 clk latency
        en = 1'b0;
        leds_in = 3'b101;
        cycle();
        cycle();
        chk("bypass_pins", 32'(led_pwm), 32'h2);
        chk("bypass_busy", 32'(busy), 32'h0);
        repeat (4) cycle();
        en = 1'b1;
        repeat (8) cycle();
        chk("bypass_to_fade_pins", 32'(led_pwm), 32'h2);

        // Randomized pattern and mode changes
        repeat (600) begin
            if ($urandom_range(7) == 0) leds_in = 3'($urandom_range(7));
            en = ($urandom_range(4) != 0);
            cycle();
        end

        // Async reset in the middle of a fade at duty 10
        en = 1'b1;
        leds_in = 3'b000;
        repeat (70) cycle();
        leds_in = 3'b001;
        run_until_duty0(10, 80);
        async_reset(2);
        repeat (70) cycle();
        chk("restart_full_pins", 32'(led_pwm), 32'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
